// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control unit: decodes ir[31:27] and drives every datapath strobe
// from a registered state (Moore outputs), with pause-at-boundary and halt.
module control_sequencer #(
  parameter int         MULDIV_WAIT = 0,
  parameter logic [4:0] ADD_OP      = 5'b00011
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        stop,
  output logic        run,
  output logic [4:0]  operation,
  output logic        PCout, ZLowout, ZHighout, MDRout, HIout, LOout, InPortout, Cout,
  output logic        MAR_enable, MDR_enable, IR_enable, Y_enable, PC_enable, IncPC,
  output logic        Z_low_enable, Z_high_enable, HI_enable, LO_enable, Output_port_enable,
  output logic        Read, Write,
  output logic        GRA, GRB, GRC, Rin, Rout, BAout, CON_in
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7,
    S_MD_WAIT, S_MD_LO, S_MD_HI, S_PAUSE, S_HALT
  } state_t;

  localparam int CW = (MULDIV_WAIT > 1) ? $clog2(MULDIV_WAIT + 1) : 1;

  state_t        state, next;
  logic [CW-1:0] cnt;
  logic          last;

  logic [4:0] opc;
  logic       unused_ir;
  assign opc       = ir[31:27];
  assign unused_ir = ^ir[26:0];

  logic c_ld, c_ldi, c_st, c_addr, c_alu, c_imm, c_md, c_neg, c_br;
  logic c_jr, c_jal, c_in, c_out, c_mfhi, c_mflo, c_nop, c_halt;
  assign c_ld   = opc == 5'd0;
  assign c_ldi  = opc == 5'd1;
  assign c_st   = opc == 5'd2;
  assign c_addr = c_ld | c_ldi | c_st;
  assign c_alu  = opc >= 5'd3 && opc <= 5'd11;
  assign c_imm  = opc >= 5'd12 && opc <= 5'd14;
  assign c_md   = opc == 5'd15 || opc == 5'd16;
  assign c_neg  = opc == 5'd17 || opc == 5'd18;
  assign c_br   = opc == 5'd19;
  assign c_jr   = opc == 5'd20;
  assign c_jal  = opc == 5'd21;
  assign c_in   = opc == 5'd22;
  assign c_out  = opc == 5'd23;
  assign c_mfhi = opc == 5'd24;
  assign c_mflo = opc == 5'd25;
  assign c_nop  = opc == 5'd26 || opc[4:2] == 3'b111;
  assign c_halt = opc == 5'd27;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= S_RESET;
    else        state <= next;
  end

  // Wait counter is armed while the mul/div operands are issued in T4.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear)                  cnt <= '0;
    else if (state == S_T4)      cnt <= CW'(MULDIV_WAIT);
    else if (state == S_MD_WAIT) cnt <= cnt - CW'(1);
  end

  always_comb begin
    next = state;
    last = 1'b0;
    run = 1'b0; operation = 5'd0;
    PCout = 1'b0; ZLowout = 1'b0; ZHighout = 1'b0; MDRout = 1'b0;
    HIout = 1'b0; LOout = 1'b0; InPortout = 1'b0; Cout = 1'b0;
    MAR_enable = 1'b0; MDR_enable = 1'b0; IR_enable = 1'b0; Y_enable = 1'b0;
    PC_enable = 1'b0; IncPC = 1'b0;
    Z_low_enable = 1'b0; Z_high_enable = 1'b0; HI_enable = 1'b0; LO_enable = 1'b0;
    Output_port_enable = 1'b0;
    Read = 1'b0; Write = 1'b0;
    GRA = 1'b0; GRB = 1'b0; GRC = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0; CON_in = 1'b0;

    run = !(state inside {S_RESET, S_PAUSE, S_HALT});

    case (state)
      S_RESET: next = S_T0;
      S_T0: begin PCout = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1; next = S_T1; end
      S_T1: begin Read = 1'b1; MDR_enable = 1'b1; next = S_T2; end
      S_T2: begin
        MDRout = 1'b1; IR_enable = 1'b1;
        if (c_halt)     next = S_HALT;
        else if (c_nop) last = 1'b1;
        else            next = S_T3;
      end
      S_T3: begin
        next = S_T4;
        if (c_alu) begin GRB = 1'b1; Rout = 1'b1; Y_enable = 1'b1; end
        else if (c_addr || c_imm) begin GRB = 1'b1; Rout = 1'b1; BAout = 1'b1; Y_enable = 1'b1; end
        else if (c_md) begin GRA = 1'b1; Rout = 1'b1; Y_enable = 1'b1; end
        else if (c_neg) begin GRB = 1'b1; Rout = 1'b1; Z_low_enable = 1'b1; operation = opc; end
        else if (c_br) begin GRA = 1'b1; Rout = 1'b1; CON_in = 1'b1; end
        else if (c_jr) begin GRA = 1'b1; Rout = 1'b1; PC_enable = 1'b1; last = 1'b1; end
        else if (c_jal) begin PCout = 1'b1; GRB = 1'b1; Rin = 1'b1; end
        else if (c_in) begin InPortout = 1'b1; GRA = 1'b1; Rin = 1'b1; last = 1'b1; end
        else if (c_out) begin GRA = 1'b1; Rout = 1'b1; Output_port_enable = 1'b1; last = 1'b1; end
        else if (c_mfhi) begin HIout = 1'b1; GRA = 1'b1; Rin = 1'b1; last = 1'b1; end
        else if (c_mflo) begin LOout = 1'b1; GRA = 1'b1; Rin = 1'b1; last = 1'b1; end
        else last = 1'b1;
      end
      S_T4: begin
        next = S_T5;
        if (c_alu) begin GRC = 1'b1; Rout = 1'b1; Z_low_enable = 1'b1; operation = opc; end
        else if (c_addr || c_imm) begin
          Cout = 1'b1; Z_low_enable = 1'b1; operation = c_imm ? opc : ADD_OP;
        end
        else if (c_md) begin
          GRB = 1'b1; Rout = 1'b1; Z_low_enable = 1'b1; Z_high_enable = 1'b1; operation = opc;
          next = (MULDIV_WAIT > 0) ? S_MD_WAIT : S_MD_LO;
        end
        else if (c_neg) begin ZLowout = 1'b1; GRA = 1'b1; Rin = 1'b1; last = 1'b1; end
        else if (c_br) begin PCout = 1'b1; Y_enable = 1'b1; end
        else if (c_jal) begin GRA = 1'b1; Rout = 1'b1; PC_enable = 1'b1; last = 1'b1; end
        else last = 1'b1;
      end
      S_T5: begin
        next = S_T6;
        if (c_alu || c_imm || c_ldi) begin ZLowout = 1'b1; GRA = 1'b1; Rin = 1'b1; last = 1'b1; end
        else if (c_ld || c_st) begin ZLowout = 1'b1; MAR_enable = 1'b1; end
        else if (c_br) begin Cout = 1'b1; Z_low_enable = 1'b1; operation = ADD_OP; end
        else last = 1'b1;
      end
      S_T6: begin
        next = S_T7;
        if (c_ld) begin Read = 1'b1; MDR_enable = 1'b1; end
        else if (c_st) begin GRA = 1'b1; Rout = 1'b1; MDR_enable = 1'b1; end
        else begin
          // Branch target only commits when the condition flip-flop is set.
          if (c_br && con_ff) begin ZLowout = 1'b1; PC_enable = 1'b1; end
          last = 1'b1;
        end
      end
      S_T7: begin
        if (c_ld) begin MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
        else if (c_st) Write = 1'b1;
        last = 1'b1;
      end
      S_MD_WAIT: if (cnt == CW'(1)) next = S_MD_LO;
      S_MD_LO: begin ZLowout = 1'b1; LO_enable = 1'b1; next = S_MD_HI; end
      S_MD_HI: begin ZHighout = 1'b1; HI_enable = 1'b1; last = 1'b1; end
      S_PAUSE: if (!stop) next = S_T0;
      S_HALT: next = S_HALT;
      default: next = S_RESET;
    endcase

    if (last) next = stop ? S_PAUSE : S_T0;
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a per-cycle vector table of expected strobes plus
// hand-written reset, halt and abort sequences.
module tb_control_sequencer;

  logic        clock = 1'b0, clear = 1'b0, con_ff = 1'b0, stop = 1'b0;
  logic [31:0] ir = 32'h0;
  logic        run;
  logic [4:0]  operation;
  logic PCout, ZLowout, ZHighout, MDRout, HIout, LOout, InPortout, Cout;
  logic MAR_enable, MDR_enable, IR_enable, Y_enable, PC_enable, IncPC;
  logic Z_low_enable, Z_high_enable, HI_enable, LO_enable, Output_port_enable;
  logic Read, Write, GRA, GRB, GRC, Rin, Rout, BAout, CON_in;

  control_sequencer #(.MULDIV_WAIT(3), .ADD_OP(5'b00011)) dut (
    .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff), .stop(stop),
    .run(run), .operation(operation),
    .PCout(PCout), .ZLowout(ZLowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
    .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .IR_enable(IR_enable),
    .Y_enable(Y_enable), .PC_enable(PC_enable), .IncPC(IncPC),
    .Z_low_enable(Z_low_enable), .Z_high_enable(Z_high_enable), .HI_enable(HI_enable),
    .LO_enable(LO_enable), .Output_port_enable(Output_port_enable),
    .Read(Read), .Write(Write), .GRA(GRA), .GRB(GRB), .GRC(GRC),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .CON_in(CON_in)
  );

  always #5 clock = ~clock;

  localparam logic [27:0] PCO  = 28'd1 << 0,  ZLO  = 28'd1 << 1,  ZHO  = 28'd1 << 2,  MDRO = 28'd1 << 3;
  localparam logic [27:0] HIO  = 28'd1 << 4,  LOO  = 28'd1 << 5,  INPO = 28'd1 << 6,  CO   = 28'd1 << 7;
  localparam logic [27:0] MARE = 28'd1 << 8,  MDRE = 28'd1 << 9,  IRE  = 28'd1 << 10, YE   = 28'd1 << 11;
  localparam logic [27:0] PCE  = 28'd1 << 12, INC  = 28'd1 << 13, ZLE  = 28'd1 << 14, ZHE  = 28'd1 << 15;
  localparam logic [27:0] HIE  = 28'd1 << 16, LOE  = 28'd1 << 17, OPE  = 28'd1 << 18, RD   = 28'd1 << 19;
  localparam logic [27:0] WR   = 28'd1 << 20, GA   = 28'd1 << 21, GB   = 28'd1 << 22, GC   = 28'd1 << 23;
  localparam logic [27:0] RIN  = 28'd1 << 24, ROUT = 28'd1 << 25, BAO  = 28'd1 << 26, CONI = 28'd1 << 27;

  localparam logic [31:0] I_ADD = 32'h18918000, I_LD  = 32'h00900065, I_ST   = 32'h10900065;
  localparam logic [31:0] I_ADDI= 32'h60900005, I_NEG = 32'h88900000, I_JAL  = 32'hA8900000;
  localparam logic [31:0] I_IN  = 32'hB0800000, I_MFHI= 32'hC0800000, I_NOP  = 32'hD0000000;
  localparam logic [31:0] I_X28 = 32'hE0000000, I_BR  = 32'h99000009, I_MUL  = 32'h80900000;
  localparam logic [31:0] I_HALT= 32'hD8000000;

  logic [33:0] obs;
  assign obs = {run, operation,
                CON_in, BAout, Rout, Rin, GRC, GRB, GRA, Write, Read, Output_port_enable,
                LO_enable, HI_enable, Z_high_enable, Z_low_enable, IncPC, PC_enable, Y_enable,
                IR_enable, MDR_enable, MAR_enable, Cout, InPortout, LOout, HIout, MDRout,
                ZHighout, ZLowout, PCout};

  typedef struct {
    logic [31:0] ir;
    logic        con_ff;
    logic        stop;
    logic [33:0] exp;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0, n_bad = 0;

  task automatic push(input logic [31:0] i, input logic c, input logic s,
                      input logic r, input logic [4:0] op, input logic [27:0] st);
    vec_t v;
    v.ir = i; v.con_ff = c; v.stop = s; v.exp = {r, op, st};
    vq.push_back(v);
  endtask

  task automatic fetch(input logic [31:0] i, input logic c);
    push(i, c, 1'b0, 1'b1, 5'd0, PCO | MARE | INC);
    push(i, c, 1'b0, 1'b1, 5'd0, RD | MDRE);
    push(i, c, 1'b0, 1'b1, 5'd0, MDRO | IRE);
  endtask

  task automatic chk(input string nm, input logic [33:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, obs, exp);
    end
  endtask

  task automatic build_table;
    fetch(I_ADD, 0);
    push(I_ADD, 0, 0, 1, 5'd0, GB | ROUT | YE);
    push(I_ADD, 0, 0, 1, 5'b00011, GC | ROUT | ZLE);
    push(I_ADD, 0, 0, 1, 5'd0, ZLO | GA | RIN);
    fetch(I_LD, 0);
    push(I_LD, 0, 0, 1, 5'd0, GB | ROUT | BAO | YE);
    push(I_LD, 0, 0, 1, 5'b00011, CO | ZLE);
    push(I_LD, 0, 0, 1, 5'd0, ZLO | MARE);
    push(I_LD, 0, 0, 1, 5'd0, RD | MDRE);
    push(I_LD, 0, 0, 1, 5'd0, MDRO | GA | RIN);
    fetch(I_ST, 0);
    push(I_ST, 0, 0, 1, 5'd0, GB | ROUT | BAO | YE);
    push(I_ST, 0, 0, 1, 5'b00011, CO | ZLE);
    push(I_ST, 0, 0, 1, 5'd0, ZLO | MARE);
    push(I_ST, 0, 0, 1, 5'd0, GA | ROUT | MDRE);
    push(I_ST, 0, 0, 1, 5'd0, WR);
    fetch(I_ADDI, 0);
    push(I_ADDI, 0, 0, 1, 5'd0, GB | ROUT | BAO | YE);
    push(I_ADDI, 0, 0, 1, 5'b01100, CO | ZLE);
    push(I_ADDI, 0, 0, 1, 5'd0, ZLO | GA | RIN);
    fetch(I_NEG, 0);
    push(I_NEG, 0, 0, 1, 5'b10001, GB | ROUT | ZLE);
    push(I_NEG, 0, 0, 1, 5'd0, ZLO | GA | RIN);
    fetch(I_JAL, 0);
    push(I_JAL, 0, 0, 1, 5'd0, PCO | GB | RIN);
    push(I_JAL, 0, 0, 1, 5'd0, GA | ROUT | PCE);
    fetch(I_IN, 0);
    push(I_IN, 0, 0, 1, 5'd0, INPO | GA | RIN);
    fetch(I_MFHI, 0);
    push(I_MFHI, 0, 0, 1, 5'd0, HIO | GA | RIN);
    fetch(I_NOP, 0);
    fetch(I_X28, 0);
    for (int c = 1; c >= 0; c--) begin
      fetch(I_BR, c[0]);
      push(I_BR, c[0], 0, 1, 5'd0, GA | ROUT | CONI);
      push(I_BR, c[0], 0, 1, 5'd0, PCO | YE);
      push(I_BR, c[0], 0, 1, 5'b00011, CO | ZLE);
      push(I_BR, c[0], 0, 1, 5'd0, c[0] ? (ZLO | PCE) : 28'd0);
    end
    fetch(I_MUL, 0);
    push(I_MUL, 0, 0, 1, 5'd0, GA | ROUT | YE);
    push(I_MUL, 0, 0, 1, 5'b10000, GB | ROUT | ZLE | ZHE);
    for (int w = 0; w < 3; w++) push(I_MUL, 0, 0, 1, 5'd0, 28'd0);
    push(I_MUL, 0, 0, 1, 5'd0, ZLO | LOE);
    push(I_MUL, 0, 0, 1, 5'd0, ZHO | HIE);
    // stop raised on add's last step: pause until it drops, then fetch resumes
    fetch(I_ADD, 0);
    push(I_ADD, 0, 0, 1, 5'd0, GB | ROUT | YE);
    push(I_ADD, 0, 0, 1, 5'b00011, GC | ROUT | ZLE);
    push(I_ADD, 0, 1, 1, 5'd0, ZLO | GA | RIN);
    push(I_ADD, 0, 1, 0, 5'd0, 28'd0);
    push(I_ADD, 0, 0, 0, 5'd0, 28'd0);
    fetch(I_HALT, 0);
  endtask

  initial begin
    build_table();
    repeat (2) @(negedge clock);
    #1 chk("reset_state", 34'd0);
    @(negedge clock);
    clear = 1'b1;
    foreach (vq[i]) begin
      @(negedge clock);
      ir = vq[i].ir; con_ff = vq[i].con_ff; stop = vq[i].stop;
      #1 chk($sformatf("vec%0d", i), vq[i].exp);
    end

    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      #1 chk($sformatf("halt%0d", k), 34'd0);
    end

    // Abort an add mid-T5 with clear, then recover.
    @(negedge clock); clear = 1'b0;
    @(negedge clock); clear = 1'b1; ir = I_ADD;
    @(negedge clock); #1 chk("leave_halt_t0", {1'b1, 5'd0, PCO | MARE | INC});
    repeat (5) @(negedge clock);
    #1 chk("abort_pre_t5", {1'b1, 5'd0, ZLO | GA | RIN});
    clear = 1'b0;
    #1 chk("abort_same_cycle", 34'd0);
    @(negedge clock); #1 chk("abort_held", 34'd0);
    clear = 1'b1;
    @(negedge clock); #1 chk("release_t0", {1'b1, 5'd0, PCO | MARE | INC});
    @(negedge clock); #1 chk("release_t1", {1'b1, 5'd0, RD | MDRE});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
